// File: rtl/cla16_mpadd_seq_pkg.sv
// Shared definitions for the multi-precision add/subtract sequencer:
// word width, FSM encodings and the whole-operand flag bundle.
package alu_pkg;

    localparam int WORD_W = 16;

    typedef logic [0:0] state_t;
    localparam state_t ST_FIRST = 1'b0;
    localparam state_t ST_MID   = 1'b1;

    typedef struct packed {
        logic cout;
        logic sign;
        logic zero;
        logic parity;
        logic ovf;
        logic err;
    } flags_t;

    function automatic logic word_parity(input logic [WORD_W-1:0] w);
        return ^w;
    endfunction

endpackage

// File: rtl/cla16_mpadd_seq_if.sv
// Operand-in / result-out streaming bundle for the multi-precision sequencer.
interface cla16_mpadd_seq_if;
    import alu_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [WORD_W-1:0] in_a;
    logic [WORD_W-1:0] in_b;
    logic              in_sub;
    logic              in_last;

    logic              out_valid;
    logic              out_ready;
    logic [WORD_W-1:0] out_sum;
    logic              out_last;
    logic              out_cout;
    logic              out_sign;
    logic              out_zero;
    logic              out_parity;
    logic              out_ovf;
    logic              out_err;

    modport master (
        output in_valid, in_a, in_b, in_sub, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_last, out_cout,
               out_sign, out_zero, out_parity, out_ovf, out_err
    );

    modport slave (
        input  in_valid, in_a, in_b, in_sub, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_last, out_cout,
               out_sign, out_zero, out_parity, out_ovf, out_err
    );

endinterface

// File: rtl/cla16_mpadd_seq_cla16.sv
// 16-bit carry-lookahead adder built from four 4-bit groups; purely combinational.
module cla16 (
    input  logic [15:0] i_a,
    input  logic [15:0] i_b,
    input  logic        i_cin,
    output logic [15:0] o_sum,
    output logic        o_cout,
    output logic        o_ovf
);

    logic [15:0] w_p;
    logic [15:0] w_g;
    logic [3:0]  w_gp;
    logic [3:0]  w_gg;
    logic [4:0]  w_cgrp;
    logic [16:0] w_cbit;

    assign w_p = i_a ^ i_b;
    assign w_g = i_a & i_b;

    // Group propagate/generate, then group carries and in-group bit carries
    always_comb begin
        w_gp   = 4'b0000;
        w_gg   = 4'b0000;
        w_cgrp = 5'b00000;
        w_cbit = 17'b0;
        w_cgrp[0] = i_cin;
        for (int k = 0; k < 4; k++) begin
            w_gp[k] = &w_p[4*k +: 4];
            w_gg[k] = w_g[4*k+3]
                    | (w_p[4*k+3] & w_g[4*k+2])
                    | (w_p[4*k+3] & w_p[4*k+2] & w_g[4*k+1])
                    | (w_p[4*k+3] & w_p[4*k+2] & w_p[4*k+1] & w_g[4*k]);
            w_cgrp[k+1] = w_gg[k] | (w_gp[k] & w_cgrp[k]);
        end
        for (int k = 0; k < 4; k++) begin
            w_cbit[4*k] = w_cgrp[k];
            for (int j = 0; j < 3; j++) begin
                w_cbit[4*k+j+1] = w_g[4*k+j] | (w_p[4*k+j] & w_cbit[4*k+j]);
            end
        end
        w_cbit[16] = w_cgrp[4];
    end

    assign o_sum  = w_p ^ w_cbit[15:0];
    assign o_cout = w_cbit[16];
    assign o_ovf  = w_cbit[16] ^ w_cbit[15];

endmodule

// File: rtl/cla16_mpadd_seq.sv
// Multi-precision add/subtract sequencer: streams 16-bit words LS-first through
// cla16, chains the carry and reports whole-operand flags on the last word.
module cla16_mpadd_seq
    import alu_pkg::*;
#(
    parameter int MAX_WORDS = 8,
    parameter int CW        = $clog2(MAX_WORDS)
) (
    input  logic              clk,
    input  logic              rst_n,
    cla16_mpadd_seq_if.slave  bus
);

    localparam logic [CW-1:0] LAST_IDX = CW'(MAX_WORDS - 1);

    state_t            r_state;
    logic [CW-1:0]     r_cnt;
    logic              r_carry;
    logic              r_sub;
    logic              r_zero_acc;
    logic              r_par_acc;

    logic              r_out_valid;
    logic [WORD_W-1:0] r_out_sum;
    logic              r_out_last;
    flags_t            r_flags;

    logic              w_in_ready;
    logic              w_accept;
    logic              w_first;
    logic              w_sub;
    logic [WORD_W-1:0] w_y;
    logic              w_cin;
    logic [WORD_W-1:0] w_sum;
    logic              w_cout;
    logic              w_ovf;
    logic [CW-1:0]     w_idx;
    logic              w_term;
    logic              w_end;
    logic              w_zero;
    logic              w_par;
    flags_t            w_flags;

    assign w_in_ready = !r_out_valid || bus.out_ready;
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_first    = (r_state == ST_FIRST);

    // Operation and incoming carry are latched from the first word only
    assign w_sub = w_first ? bus.in_sub : r_sub;
    assign w_y   = w_sub ? ~bus.in_b : bus.in_b;
    assign w_cin = w_first ? bus.in_sub : r_carry;

    cla16 u_cla16 (
        .i_a    (bus.in_a),
        .i_b    (w_y),
        .i_cin  (w_cin),
        .o_sum  (w_sum),
        .o_cout (w_cout),
        .o_ovf  (w_ovf)
    );

    // w_idx is the position of the current word within its transaction
    assign w_idx  = w_first ? {CW{1'b0}} : r_cnt;
    assign w_term = (w_idx == LAST_IDX);
    assign w_end  = bus.in_last || w_term;
    assign w_zero = (w_first ? 1'b1 : r_zero_acc) & (w_sum == {WORD_W{1'b0}});
    assign w_par  = (w_first ? 1'b0 : r_par_acc) ^ word_parity(w_sum);

    // Flag fields are only meaningful on the closing word of a transaction
    always_comb begin
        w_flags = '0;
        if (w_end) begin
            w_flags.cout   = w_cout;
            w_flags.sign   = w_sum[WORD_W-1];
            w_flags.zero   = w_zero;
            w_flags.parity = w_par;
            w_flags.ovf    = w_ovf;
            w_flags.err    = w_term && !bus.in_last;
        end else begin
            w_flags = '0;
        end
    end

    // Transaction state: FSM, word counter, carry chain and sticky accumulators
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_FIRST;
            r_cnt      <= {CW{1'b0}};
            r_carry    <= 1'b0;
            r_sub      <= 1'b0;
            r_zero_acc <= 1'b1;
            r_par_acc  <= 1'b0;
        end else if (w_accept) begin
            r_state    <= w_end ? ST_FIRST : ST_MID;
            r_cnt      <= w_idx + CW'(1'b1);
            r_carry    <= w_cout;
            r_sub      <= w_sub;
            r_zero_acc <= w_zero;
            r_par_acc  <= w_par;
        end
    end

    // Single output stage; holds while the sink stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_sum   <= {WORD_W{1'b0}};
            r_out_last  <= 1'b0;
            r_flags     <= '0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_sum   <= w_sum;
            r_out_last  <= w_end;
            r_flags     <= w_flags;
        end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.out_valid  = r_out_valid;
    assign bus.out_sum    = r_out_sum;
    assign bus.out_last   = r_out_last;
    assign bus.out_cout   = r_flags.cout;
    assign bus.out_sign   = r_flags.sign;
    assign bus.out_zero   = r_flags.zero;
    assign bus.out_parity = r_flags.parity;
    assign bus.out_ovf    = r_flags.ovf;
    assign bus.out_err    = r_flags.err;

endmodule

// File: tb/tb_cla16_mpadd_seq.sv
// Scoreboard bench for cla16_mpadd_seq: directed words push expected results,
// an output monitor pops and compares each delivered word.
module tb_cla16_mpadd_seq;

    typedef struct {
        logic [15:0] sum;
        logic        last;
        logic [5:0]  flags;   // {cout, sign, zero, parity, ovf, err}
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_fail;
    int   last_wait;
    exp_t sb_q[$];

    cla16_mpadd_seq_if bus_if();

    cla16_mpadd_seq #(.MAX_WORDS(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [5:0] fl(input logic c, s, z, p, o, e);
        return {c, s, z, p, o, e};
    endfunction

    function automatic logic [5:0] dut_flags();
        return {bus_if.out_cout, bus_if.out_sign, bus_if.out_zero,
                bus_if.out_parity, bus_if.out_ovf, bus_if.out_err};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Output monitor: compare each word the sink actually takes
    always @(negedge clk) begin
        if (rst_n && bus_if.out_valid && bus_if.out_ready) begin
            n_cmp++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_word: got sum=%h last=%b flags=%b with empty scoreboard",
                         bus_if.out_sum, bus_if.out_last, dut_flags());
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                if ({bus_if.out_sum, bus_if.out_last, dut_flags()} !== {e.sum, e.last, e.flags}) begin
                    n_fail++;
                    $display("FAIL word: got sum=%h last=%b flags=%b expected sum=%h last=%b flags=%b",
                             bus_if.out_sum, bus_if.out_last, dut_flags(), e.sum, e.last, e.flags);
                end
            end
        end
    end

    task automatic send(input logic [15:0] a, b, input logic sub, last,
                        input logic [15:0] es, input logic el, input logic [5:0] ef);
        exp_t e;
        int   n;
        n = 0;
        bus_if.in_a     = a;
        bus_if.in_b     = b;
        bus_if.in_sub   = sub;
        bus_if.in_last  = last;
        bus_if.in_valid = 1'b1;
        @(negedge clk);
        while (!bus_if.in_ready && n < 100) begin
            n++;
            @(negedge clk);
        end
        last_wait = n;
        if (!bus_if.in_ready) begin
            n_cmp++;
            n_fail++;
            $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles, required 1", n);
            bus_if.in_valid = 1'b0;
        end else begin
            e.sum   = es;
            e.last  = el;
            e.flags = ef;
            sb_q.push_back(e);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle(input int cycles);
        bus_if.in_valid = 1'b0;
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        last_wait = 0;
        rst_n = 1'b0;
        bus_if.in_valid  = 1'b0;
        bus_if.in_a      = 16'h0000;
        bus_if.in_b      = 16'h0000;
        bus_if.in_sub    = 1'b0;
        bus_if.in_last   = 1'b0;
        bus_if.out_ready = 1'b1;

        #3;
        check("reset_out_valid", 32'(bus_if.out_valid), 32'd0);
        check("reset_outputs", {15'd0, bus_if.out_sum, bus_if.out_last, 
                                32'(dut_flags()) == 32'd0 ? 1'b0 : 1'b1}, 32'd0);
        check("reset_in_ready", 32'(bus_if.in_ready), 32'd1);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(1);

        // Single-word add and add with signed overflow into the sign bit
        send(16'h000A, 16'h0005, 1'b0, 1'b1, 16'h000F, 1'b1, fl(0,0,0,0,0,0));
        send(16'h7FFF, 16'h0001, 1'b0, 1'b1, 16'h8000, 1'b1, fl(0,1,0,1,1,0));

        // Two-word add, back to back: 0x0001_FFFF + 0x0000_0001
        send(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b0, fl(0,0,0,0,0,0));
        send(16'h0001, 16'h0000, 1'b0, 1'b1, 16'h0002, 1'b1, fl(0,0,0,1,0,0));
        check("back_to_back_wait", 32'(last_wait), 32'd0);

        // Two-word add with an idle gap: 0x0000_8000 + 0x0000_8000
        send(16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b0, fl(0,0,0,0,0,0));
        idle(2);
        send(16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0001, 1'b1, fl(0,0,0,1,0,0));

        // Subtract overflow: 0x8000 - 0x0001
        send(16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, fl(1,0,0,1,1,0));

        // Equal subtract with a sink stall before the last word; in_sub=0 on word 2 is ignored
        send(16'h5678, 16'h5678, 1'b1, 1'b0, 16'h0000, 1'b0, fl(0,0,0,0,0,0));
        bus_if.out_ready = 1'b0;
        fork
            send(16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b1, fl(1,0,1,0,0,0));
            begin
                repeat (3) begin
                    @(negedge clk);
                    check("stall_in_ready", 32'(bus_if.in_ready), 32'd0);
                    check("stall_hold", {14'd0, bus_if.out_valid, bus_if.out_sum, bus_if.out_last},
                          {14'd0, 1'b1, 16'h0000, 1'b0});
                end
                @(posedge clk);
                #1 bus_if.out_ready = 1'b1;
            end
        join

        // Forced termination: nine words, in_last never set, then a closing word
        for (int i = 1; i <= 9; i++) begin
            send(16'h0001, 16'h0000, 1'b0, 1'b0, 16'h0001, (i == 8),
                 (i == 8) ? fl(0,0,0,0,0,1) : fl(0,0,0,0,0,0));
        end
        send(16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, fl(0,0,0,1,0,0));

        // Reset after two of four carry-generating words
        send(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b0, fl(0,0,0,0,0,0));
        send(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0001, 1'b0, fl(0,0,0,0,0,0));
        bus_if.in_valid = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midreset_out_valid", 32'(bus_if.out_valid), 32'd0);
        check("midreset_sum_last", {15'd0, bus_if.out_sum, bus_if.out_last}, 32'd0);
        check("midreset_flags", 32'(dut_flags()), 32'd0);
        check("midreset_pending", 32'(sb_q.size()), 32'd0);
        sb_q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(1);
        send(16'h000A, 16'h0005, 1'b0, 1'b1, 16'h000F, 1'b1, fl(0,0,0,0,0,0));

        idle(1);
        begin
            int n;
            n = 0;
            while (sb_q.size() != 0 && n < 50) begin
                n++;
                @(posedge clk);
            end
        end
        check("drain_empty", 32'(sb_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/cla16_mpadd_seq.md
Name: cla16_mpadd_seq

Overview:
- Multi-precision add/subtract sequencer that sits directly upstream of cla16 and feeds it one 16-bit word per cycle, least-significant word first.
- Chains carry between words and registers each cla16 result into a single output stage.
- Produces whole-operand Sign/Zero/Parity/Overflow/carry flags on the last word.
- Uses valid/ready streaming on both sides, so it plugs between an operand source and a result sink.

Parameters:
- MAX_WORDS, 8, maximum words per transaction (2..256); longer streams are force-terminated.
- CW, $clog2(MAX_WORDS), width of the internal word counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input word valid.
- in_ready  out  1  input word accepted when in_valid && in_ready.
- in_a  in  16  operand A word.
- in_b  in  16  operand B word.
- in_sub  in  1  1 = A-B, 0 = A+B; sampled only on the first word of a transaction.
- in_last  in  1  marks the most-significant word.
- out_valid  out  1  result word valid.
- out_ready  in  1  sink accepts when out_valid && out_ready.
- out_sum  out  16  result word.
- out_last  out  1  final word of the transaction.
- out_cout  out  1  carry out of the final word (sub: 1 = no borrow); 0 when out_last=0.
- out_sign  out  1  MSB of the final word; 0 when out_last=0.
- out_zero  out  1  all result words of the transaction are zero; 0 when out_last=0.
- out_parity  out  1  XOR of every result bit in the transaction (1 = odd count of ones); 0 when out_last=0.
- out_ovf  out  1  signed overflow of the final word, from cla16; 0 when out_last=0.
- out_err  out  1  transaction hit MAX_WORDS without in_last; valid with out_last.

Behaviour:
- Reset (async, rst_n=0): all outputs 0, state=FIRST, carry reg 0, counter 0, sticky zero=1, sticky parity=0, sub reg 0. Reset mid-transaction discards partial state; the next accepted word is a FIRST word.
- Flow control: in_ready = !out_valid || out_ready.
- Latency: one cycle from input accept to out_valid. Full throughput of one word per clock when out_ready is held high.
- Output stability: out_* hold stable while out_valid && !out_ready.
- Datapath per accepted word:
  - X = in_a; Y = sub ? ~in_b : in_b.
  - cin = in_sub on a FIRST word; otherwise the stored carry.
  - sub = in_sub on a FIRST word; otherwise the sub reg.
  - cla16 cout is stored to the carry reg.
- Sticky flags:
  - zero_acc = (FIRST ? 1 : zero_acc) & (S==0).
  - par_acc = (FIRST ? 0 : par_acc) ^ ^S.
  - Output flag fields take their values on the last word.
- State machine:
  - FIRST -> MID on accept with !in_last and counter != MAX_WORDS-1.
  - MID -> FIRST on accept with in_last.
  - Either state -> FIRST on accept when counter == MAX_WORDS-1.
- Counter: reset to 0 on FIRST-word accept, otherwise incremented on each accept.
- Forced termination: when counter == MAX_WORDS-1 and in_last=0, the word is output with out_last=1 and out_err=1, and flags are computed as normal. The next word starts a new transaction.
- Single-word transaction: FIRST with in_last=1 stays in FIRST; all flags come from that word alone.
- Ordering: no transaction overlap; word order is preserved.
- Idle cycles: valid may drop between words of a transaction; state holds.
- in_sub on non-first words is ignored.

Decomposition:
- Shared package alu_pkg:
  - WORD_W=16.
  - State enum {FIRST, MID}.
  - A flag-bundle typedef {cout, sign, zero, parity, ovf, err}.
- Sub-module: the existing cla16, one instance. It is purely combinational; all registers live in cla16_mpadd_seq.

Test Plan:
- Single add: A=0x000A, B=0x0005, sub=0, last -> sum 0x000F, out_last=1, cout 0, sign 0, zero 0, parity 0, ovf 0, err 0.
- Two-word add, out_ready=1: A=0x0001_FFFF, B=0x0000_0001 -> words 0x0000 (out_last=0, flags 0) then 0x0002 (out_last=1, cout 0, zero 0, parity 1, ovf 0), back-to-back cycles.
- Sub overflow: sub=1, A=0x8000, B=0x0001, last -> sum 0x7FFF, cout 1, ovf 1, sign 0, parity 1, zero 0.
- Two-word equal subtract: 0x1234_5678 - 0x1234_5678 -> 0x0000, 0x0000; zero 1, cout 1, parity 0. Then hold out_ready=0 with in_valid=1: in_ready=0, out_* stable, no words lost once out_ready rises.
- Forced termination: MAX_WORDS=8, 0x0001+0x0000 for 9 words, in_last never set -> 8th output has out_last=1, err=1; 9th word is treated as FIRST and output with out_err=0.
- Reset mid-transaction: drop rst_n after 2 of 4 words -> outputs 0 immediately. The next word, 0x000A+0x0005 with last, yields 0x000F with no stale carry.
